// File: rtl/io_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_pkg : shared types and constants for the board IO blocks        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } io_state_e;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int IO_DATA_WIDTH           = 32;

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_debounce : sync, debounce and press-edge detect for a KEY input |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module io_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_stable_d;
  logic               r_press;
  logic [c_CNT_W-1:0] r_cnt;

  // The counter only runs while the synced key disagrees with the accepted level,
  // so any bounce back to the old level restarts the qualification window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= ~key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/io_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_input_ctrl : stalls the core on an Input instruction and        |
// | captures the slide switches on a debounced Enter press             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 10,
  parameter int DATA_WIDTH      = IO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Input,
  input  logic                  Enter,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic                  stall,
  output logic                  in_done,
  output logic [DATA_WIDTH-1:0] Input_Data,
  output logic [DATA_WIDTH-1:0] sw_live
);

  io_state_e             r_state;
  io_state_e             w_next;
  logic                  w_press;
  logic                  w_capture;
  logic                  w_stall;
  logic                  w_done;
  logic [SW_WIDTH-1:0]   r_sw_sync1;
  logic [SW_WIDTH-1:0]   r_sw_sync2;
  logic [DATA_WIDTH-1:0] r_input_data;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk   (clk),
    .reset (reset),
    .key_n (Enter),
    .press (w_press)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sw_sync1   <= '0;
      r_sw_sync2   <= '0;
      r_input_data <= '0;
    end else begin
      r_state    <= w_next;
      r_sw_sync1 <= sw;
      r_sw_sync2 <= r_sw_sync1;
      if (w_capture) begin
        r_input_data <= DATA_WIDTH'(r_sw_sync2);
      end
    end
  end

  // Stall in IDLE follows Input directly so the core is held on its first cycle.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_stall   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = Input;
        if (Input) begin
          w_next = ARMED;
        end
      end
      ARMED: begin
        w_stall = 1'b1;
        if (!Input) begin
          w_next = IDLE;
        end else if (w_press) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign stall      = reset & w_stall;
  assign in_done    = reset & w_done;
  assign Input_Data = r_input_data;
  assign sw_live    = DATA_WIDTH'(r_sw_sync2);

endmodule
`default_nettype wire
